// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
//
// Shares the single sprite/game-state update port between N_REQ game-logic
// requesters. Once per frame, while the VGA line counter sits inside
// [WIN_START_LINE, WIN_END_LINE], an update window opens and each requester
// may be granted at most once, in round-robin order, using a req/gnt/done
// handshake.
//
// Handshake: a requester holds req[i] high while it wants the port. gnt is
// one-hot and registered; once gnt[g] is high it stays high until the cycle
// after done[g] is seen high (done is a one-cycle pulse). done on any bit
// other than the granted one is ignored, and dropping req never revokes a
// grant. Two grants are always separated by at least one cycle with gnt=0.
//
// Optional build macro: GRANT_TIMEOUT_EN. When defined, a grant held for
// MAX_HOLD cycles without done is forcibly released and timeout pulses.
// When undefined, no hold counter exists and timeout is constant 0.
//
// Ports:
//   clk          system/pixel clock
//   rst_n        asynchronous active-low reset
//   line         signed current line from the VGA timing generator
//   req          level request per requester
//   done         one-cycle completion pulse per requester
//   gnt          one-hot grant (registered)
//   frame_tick   one-cycle pulse as the window opens
//   window_open  registered window indicator
//   busy         any grant active (registered with gnt)
//   overrun      sticky: window closed with a grant held or a request pending
//   timeout      one-cycle pulse on forced grant release
module vblank_update_scheduler #(
    parameter int N_REQ          = 4,
    parameter int CORDW          = 11,
    parameter int WIN_START_LINE = 480,
    parameter int WIN_END_LINE   = 489,
    parameter int MAX_HOLD       = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] line,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        gnt,
    output logic                    frame_tick,
    output logic                    window_open,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam logic signed [CORDW-1:0] WIN_START = CORDW'(WIN_START_LINE);
    localparam logic signed [CORDW-1:0] WIN_END   = CORDW'(WIN_END_LINE);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  served_q, served_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              window_open_q, window_open_d;
    logic              frame_tick_q, frame_tick_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  rot;
    logic              pick_found;
    logic [PW-1:0]     pick_off;
    logic [PW:0]       pick_sum;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     g_idx;
    logic              grant_done;
    logic              timeout_hit;

    // Round-robin pick: rotate eligibility so rr_ptr lands on bit 0, take the
    // lowest set bit, then rotate the offset back to an absolute index.
    always_comb begin
        eligible   = req & ~served_q & {N_REQ{window_open_q}};
        rot        = N_REQ'({eligible, eligible} >> rr_ptr_q);
        pick_found = 1'b0;
        pick_off   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!pick_found && rot[j]) begin
                pick_found = 1'b1;
                pick_off   = PW'(j);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (PW+1)'(N_REQ)) begin
            pick_sum = pick_sum - (PW+1)'(N_REQ);
        end
        pick_idx = pick_sum[PW-1:0];

        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                g_idx = PW'(i);
            end
        end
        grant_done = |(done & gnt_q);
    end

    always_comb begin
        window_open_d = (line >= WIN_START) && (line <= WIN_END);
        frame_tick_d  = window_open_d && !window_open_q;

        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        // A new window forgets who was served; a grant still in flight sets
        // its own bit again below when it completes.
        served_d = frame_tick_d ? '0 : served_q;

        overrun_d = frame_tick_d ? 1'b0 : overrun_q;
        if (window_open_q && !window_open_d && (state_q == GRANT || |eligible)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (window_open_q) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!window_open_q) begin
                    state_d = IDLE;
                end else if (pick_found) begin
                    gnt_d   = N_REQ'(1) << pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_done || timeout_hit) begin
                    gnt_d    = '0;
                    served_d = served_d | gnt_q;
                    rr_ptr_d = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);
                    state_d  = ARB;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            served_q      <= '0;
            rr_ptr_q      <= '0;
            window_open_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            served_q      <= served_d;
            rr_ptr_q      <= rr_ptr_d;
            window_open_q <= window_open_d;
            frame_tick_q  <= frame_tick_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    // Counter is 0 during the first granted cycle, so reaching MAX_HOLD-1
    // means the grant has been held for MAX_HOLD cycles.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == ARB && state_d == GRANT) begin
            hold_cnt_d = '0;
        end else if (state_q == GRANT) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
        timeout_hit = (state_q == GRANT) && (hold_cnt_q == HW'(MAX_HOLD - 1));
        // done in the same cycle wins: that is a normal completion.
        timeout_d   = timeout_hit && !grant_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // No hold limit: grants last until done. MAX_HOLD is positive, so this
    // term is constant 0.
    assign timeout_hit = (MAX_HOLD < 1);
    assign timeout     = 1'b0;
`endif

    assign gnt         = gnt_q;
    assign frame_tick  = frame_tick_q;
    assign window_open = window_open_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Shares the single sprite/game-state update port between N_REQ game-logic requesters (player, alien grid, bullets, score).
- Opens an update window once per frame, during vertical blanking, using the line coordinate from the VGA timing generator.
- Grants requesters round-robin, each at most once per window, with a req/gnt/done handshake.
- Sits between the VGA timing generator and the game-object update FSMs.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CORDW, 11, signed coordinate width, matches `CORDW
- WIN_START_LINE, 480, first line of the update window (inclusive)
- WIN_END_LINE, 489, last line of the update window (inclusive)
- MAX_HOLD, 4096, grant timeout in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- line  in  CORDW (signed)  current line from the VGA timing generator
- req  in  N_REQ  level request per requester
- done  in  N_REQ  one-cycle completion pulse per requester
- gnt  out  N_REQ  one-hot grant, registered
- frame_tick  out  1  one-cycle pulse when the window opens
- window_open  out  1  registered window indicator
- busy  out  1  any grant active
- overrun  out  1  sticky: window closed while a grant was held or a request was still pending
- timeout  out  1  one-cycle pulse on forced grant release

Behaviour:
- Reset is asynchronous, active-low and reaches all flops. Reset values:
  - gnt=0, frame_tick=0, window_open=0, busy=0, overrun=0, timeout=0
  - rr_ptr=0, served=0, state=IDLE
- window_open:
  - Registered each clk as (line >= WIN_START_LINE && line <= WIN_END_LINE), signed compare.
  - Latency is 1 cycle from line.
- frame_tick: 1 for exactly one cycle on the 0->1 edge of window_open. The same edge clears served[] and overrun.
- Eligibility: eligible[i] = req[i] & ~served[i] & window_open.
- State IDLE:
  - Move to ARB when window_open=1.
- State ARB:
  - If any eligible: pick the first eligible index scanning upward from rr_ptr, modulo N_REQ.
  - Set gnt to that one-hot value on the next edge and go to GRANT.
  - If window_open=0: go to IDLE.
- State GRANT:
  - Hold gnt until done[g]=1 for the granted index g.
  - On that edge: gnt=0, served[g]=1, rr_ptr=(g+1) mod N_REQ, go to ARB.
  - A new grant therefore cannot appear before one idle cycle has elapsed (gnt-to-gnt gap >= 1 cycle).
- done from non-granted requesters is ignored.
- If req[g] drops while granted, the grant is still held until done[g]. A grant is never revoked by req alone.
- Window close:
  - A grant in progress is not revoked.
  - overrun is set on the cycle window_open falls if state=GRANT or any eligible request existed on the previous cycle.
  - After the grant completes, the FSM returns to ARB, then to IDLE. No new grants are issued while window_open=0.
- Simultaneous events:
  - frame_tick while in GRANT (window spanning frames, degenerate parameters): served is cleared except for the bit of the current grant, which is set when done arrives.
  - done and window close in the same cycle: the grant completes normally; overrun is still set.
- busy = |gnt, registered with gnt.
- Reset mid-grant: gnt drops asynchronously; requesters must tolerate an abandoned transaction.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter clears on each new grant and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD-1 without done: gnt=0 on the next edge, served[g]=1, rr_ptr advances, timeout pulses for 1 cycle, FSM goes to ARB.
- Not defined:
  - No counter is built; timeout is tied to 0.
  - A grant is held indefinitely until done.

Test Plan (N_REQ=4, WIN 480..489, MAX_HOLD=16):
- Sweep line 479->480 with req=0000 -> window_open rises the cycle after line=480; frame_tick is a single pulse; gnt stays 0000.
- req=1111 from line 480, each requester pulses done 3 cycles after its gnt -> gnts 0001, 0010, 0100, 1000, each at most once, >=1 idle cycle between; gnt=0000 thereafter in that window.
- Next frame, rr_ptr=0, req=0101 -> grants 0001 then 0100. Pre-set rr_ptr=2 (by serving 0 and 1 last frame) -> 0100 granted first.
- req[1] granted, done withheld past line 489 -> gnt stays 0010; overrun=1 after window_open falls; done -> gnt=0000 with no further grant; overrun clears at the next frame_tick.
- GRANT_TIMEOUT_EN defined, grant 0001 and done never asserted -> after 16 cycles gnt=0000, timeout pulses once, next eligible requester granted. Without the macro -> gnt held, timeout stays 0.
- Assert rst_n=0 mid-grant -> gnt, busy, window_open, frame_tick and overrun go to 0 immediately (asynchronously, without waiting for a clk edge); after release, req=1000 in the window -> requester 3 is granted (rr_ptr restarted at 0, no lower eligible).
